ctl_xfer_initiator: RTL

CTL_XFER_INITIATOR -- requirements
Module: ctl_xfer_initiator

---
 rtl/ctl_xfer_initiator_pkg.sv | 32 +++
 rtl/ctl_xfer_initiator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ctl_xfer_initiator_pkg.sv
// Shared definitions for the control-transfer initiator: FSM encodings,
// completion status codes, request codes and the setup-type constant.
package ctl_xfer_initiator_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ARM      = 3'd1;
   localparam logic [2:0] ST_CHECK    = 3'd2;
   localparam logic [2:0] ST_DATA_OUT = 3'd3;
   localparam logic [2:0] ST_DATA_IN  = 3'd4;
   localparam logic [2:0] ST_FINISH   = 3'd5;
   localparam logic [2:0] ST_RESP     = 3'd6;

   typedef enum logic [1:0] {
      STATUS_OK      = 2'd0,
      STATUS_REJECT  = 2'd1,
      STATUS_SHORT   = 2'd2,
      STATUS_TIMEOUT = 2'd3
   } status_e;

   typedef enum logic [7:0] {
      REQ_CFG_GET  = 8'h00,
      REQ_REG_OPER = 8'h01
   } request_e;

   // Vendor request, device recipient; bit 7 carries the direction.
   localparam logic [6:0] CTL_TYPE_VENDOR_DEVICE = 7'h40;

   function automatic logic is_final_byte(input logic [15:0] cnt, input logic [15:0] len);
      return cnt == len - 16'd1;
   endfunction

endpackage

// File: rtl/ctl_xfer_initiator.sv
// Control-transfer initiator: turns a command into a setup request, streams
// the payload and reports completion. Optional no-progress timeout: CTL_TIMEOUT_EN.
module ctl_xfer_initiator
   import ctl_xfer_initiator_pkg::*;
#(
   parameter logic [3:0]  ENDPOINT       = 4'd0,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_read,
   input  logic [7:0]  cmd_request,
   input  logic [15:0] cmd_value,
   input  logic [15:0] cmd_index,
   input  logic [15:0] cmd_length,
   input  logic [7:0]  wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [7:0]  rdata,
   output logic        rdata_valid,
   output logic        rdata_last,
   input  logic        rdata_ready,
   output logic        rsp_valid,
   output logic [1:0]  rsp_status,
   output logic [15:0] rsp_count,
   input  logic        rsp_ready,
   output logic        ctl_xfer,
   output logic [3:0]  ctl_xfer_endpoint,
   output logic [7:0]  ctl_xfer_type,
   output logic [7:0]  ctl_xfer_request,
   output logic [15:0] ctl_xfer_value,
   output logic [15:0] ctl_xfer_index,
   output logic [15:0] ctl_xfer_length,
   input  logic        ctl_xfer_accept,
   input  logic        ctl_xfer_done,
   output logic [7:0]  ctl_xfer_data_out,
   output logic        ctl_xfer_data_out_valid,
   input  logic [7:0]  ctl_xfer_data_in,
   input  logic        ctl_xfer_data_in_valid,
   input  logic        ctl_xfer_data_in_last,
   output logic        ctl_xfer_data_in_ready
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be non-zero");
   end

   logic [2:0]  state_q, state_d;
   logic        ctl_xfer_q, ctl_xfer_d;
   logic        read_q, read_d;
   logic [7:0]  request_q, request_d;
   logic [15:0] value_q, value_d;
   logic [15:0] index_q, index_d;
   logic [15:0] length_q, length_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   status_e     status_q, status_d;

   logic out_hs, in_hs, to_expired;

   assign out_hs = (state_q == ST_DATA_OUT) && wdata_valid;
   assign in_hs  = (state_q == ST_DATA_IN) && ctl_xfer_data_in_valid && rdata_ready;

   assign cmd_ready               = (state_q == ST_IDLE);
   assign wdata_ready             = (state_q == ST_DATA_OUT);
   assign ctl_xfer_data_out_valid = out_hs;
   assign ctl_xfer_data_out       = (state_q == ST_DATA_OUT) ? wdata : 8'h00;
   assign ctl_xfer_data_in_ready  = (state_q == ST_DATA_IN) && rdata_ready;
   assign rdata                   = ctl_xfer_data_in;
   assign rdata_valid             = (state_q == ST_DATA_IN) && ctl_xfer_data_in_valid;
   assign rdata_last              = (state_q == ST_DATA_IN) &&
                                    (ctl_xfer_data_in_last || is_final_byte(byte_cnt_q, length_q));
   assign rsp_valid               = (state_q == ST_RESP);
   assign rsp_status              = status_q;
   assign rsp_count               = byte_cnt_q;

   assign ctl_xfer          = ctl_xfer_q;
   assign ctl_xfer_endpoint = ENDPOINT;
   assign ctl_xfer_type     = {read_q, CTL_TYPE_VENDOR_DEVICE};
   assign ctl_xfer_request  = request_q;
   assign ctl_xfer_value    = value_q;
   assign ctl_xfer_index    = index_q;
   assign ctl_xfer_length   = length_q;

`ifdef CTL_TIMEOUT_EN
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        to_active;

   assign to_active  = (state_q == ST_ARM) || (state_q == ST_CHECK) || (state_q == ST_DATA_OUT) ||
                       (state_q == ST_DATA_IN) || (state_q == ST_FINISH);
   assign to_expired = to_active && (to_cnt_q == TIMEOUT_CYCLES - 32'd1);

   // Any byte or state change counts as progress and restarts the window.
   always_comb begin
      to_cnt_d = 32'd0;
      if (to_active && !out_hs && !in_hs && (state_d == state_q)) to_cnt_d = to_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) to_cnt_q <= 32'd0;
      else        to_cnt_q <= to_cnt_d;
   end
`else
   assign to_expired = 1'b0;
`endif

   // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      ctl_xfer_d = ctl_xfer_q;
      read_d     = read_q;
      request_d  = request_q;
      value_d    = value_q;
      index_d    = index_q;
      length_d   = length_q;
      byte_cnt_d = byte_cnt_q;
      status_d   = status_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               read_d     = cmd_read;
               request_d  = cmd_request;
               value_d    = cmd_value;
               index_d    = cmd_index;
               length_d   = cmd_length;
               byte_cnt_d = 16'd0;
               status_d   = STATUS_OK;
               ctl_xfer_d = 1'b1;
               state_d    = ST_ARM;
            end
         end
         // The responder still shows the previous transfer's accept/done here.
         ST_ARM: state_d = ST_CHECK;
         ST_CHECK: begin
            if (!ctl_xfer_accept && ctl_xfer_done) begin
               status_d   = STATUS_REJECT;
               ctl_xfer_d = 1'b0;
               state_d    = ST_RESP;
            end else if (ctl_xfer_accept) begin
               if (length_q == 16'd0) state_d = ST_FINISH;
               else if (read_q)       state_d = ST_DATA_IN;
               else                   state_d = ST_DATA_OUT;
            end
         end
         ST_DATA_OUT: begin
            if (out_hs) begin
               byte_cnt_d = byte_cnt_q + 16'd1;
               if (is_final_byte(byte_cnt_q, length_q)) state_d = ST_FINISH;
            end
         end
         ST_DATA_IN: begin
            if (in_hs) byte_cnt_d = byte_cnt_q + 16'd1;
            if ((in_hs && rdata_last) || (ctl_xfer_accept && ctl_xfer_done)) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            if (ctl_xfer_accept && ctl_xfer_done) begin
               status_d   = (byte_cnt_q == length_q) ? STATUS_OK : STATUS_SHORT;
               ctl_xfer_d = 1'b0;
               state_d    = ST_RESP;
            end
         end
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (to_expired) begin
         status_d   = STATUS_TIMEOUT;
         ctl_xfer_d = 1'b0;
         state_d    = ST_RESP;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ctl_xfer_q <= 1'b0;
         read_q     <= 1'b0;
         request_q  <= 8'h00;
         value_q    <= 16'h0000;
         index_q    <= 16'h0000;
         length_q   <= 16'h0000;
         byte_cnt_q <= 16'h0000;
         status_q   <= STATUS_OK;
      end else begin
         state_q    <= state_d;
         ctl_xfer_q <= ctl_xfer_d;
         read_q     <= read_d;
         request_q  <= request_d;
         value_q    <= value_d;
         index_q    <= index_d;
         length_q   <= length_d;
         byte_cnt_q <= byte_cnt_d;
         status_q   <= status_d;
      end
   end

endmodule
